// File: rtl/alu_disp_pkg.sv
// Package: alu_disp_pkg
// Shared types and constants for the ALU result display slice:
//   - disp_state_e : conversion FSM states (IDLE, SHIFT, COMMIT)
//   - RESULT_W     : ALU result width (fixed at 6, max value 63)
//   - SEG_*        : 7-segment patterns {g,f,e,d,c,b,a}, active-high
//   - DIG_UNITS / DIG_TENS : one-hot digit enables
//   - dd_adjust()  : double-dabble add-3 correction on one BCD nibble
package alu_disp_pkg;

  localparam int unsigned RESULT_W = 6;
  localparam int unsigned BCD_W    = 8;

  // Six shift edges, counted 0..5; the FSM leaves SHIFT when the counter is at 5.
  localparam logic [2:0] SHIFT_LAST = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } disp_state_e;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] DIG_UNITS = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;

  // A nibble >= 5 would carry past 9 after the next doubling, so pre-add 3.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Module: seg7_decode
// Combinational BCD digit to 7-segment decoder. Non-decimal codes blank.
//   bcd_i [3:0] : BCD digit
//   seg_o [6:0] : segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_result_display.sv
// Module: alu_result_display
// Accepts a 6-bit ALU result on a valid/ready handshake, converts it to two
// BCD digits with a sequential double-dabble (6 shift cycles), then commits
// the digits to a two-digit time-multiplexed 7-segment display and the raw
// binary to the LEDs. One result per 8 cycles; results offered while busy
// are dropped.
// Parameters:
//   REFRESH_DIV : clk cycles each digit stays selected (2..65535)
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   result_i   : ALU result
//   valid_i    : result_i valid this cycle
//   ready_o    : high while idle (a result can be accepted)
//   leds_o     : last committed binary result
//   seg_o      : segments {g,f,e,d,c,b,a} of the selected digit, active-high
//   dig_sel_o  : one-hot digit enable, 01 units / 10 tens
// Configuration macro ALU_DISP_LZ_BLANK_EN: when defined, a zero tens digit
// is blanked; otherwise the tens digit always shows.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RESULT_W-1:0] result_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [RESULT_W-1:0] leds_o,
  output logic [6:0]          seg_o,
  output logic [1:0]          dig_sel_o
);

  localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);

  disp_state_e         state_q, state_d;
  logic [RESULT_W-1:0] bin_q, bin_d;     // shifted-out binary
  logic [RESULT_W-1:0] cap_q, cap_d;     // binary held intact for the LEDs
  logic [BCD_W-1:0]    bcd_q, bcd_d;     // {tens, units} scratch
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          units_q, units_d;
  logic [RESULT_W-1:0] leds_q, leds_d;
  logic [15:0]         ref_q, ref_d;
  logic [1:0]          dig_q, dig_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [3:0]          digit_sel;
  logic [6:0]          seg_raw;

  // Conversion FSM and datapath
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    cap_d   = cap_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    units_d = units_q;
    leds_d  = leds_q;
    bcd_adj = {dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0])};

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          bin_d   = result_i;
          cap_d   = result_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == SHIFT_LAST) state_d = COMMIT;
      end
      COMMIT: begin
        tens_d  = bcd_q[7:4];
        units_d = bcd_q[3:0];
        leds_d  = cap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit refresh mux, free-running in every FSM state
  always_comb begin
    ref_d = ref_q + 16'd1;
    dig_d = dig_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      dig_d = (dig_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      cap_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      leds_q  <= '0;
      ref_q   <= '0;
      dig_q   <= DIG_UNITS;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      cap_q   <= cap_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      leds_q  <= leds_d;
      ref_q   <= ref_d;
      dig_q   <= dig_d;
    end
  end

  assign digit_sel = (dig_q == DIG_TENS) ? tens_q : units_q;

  seg7_decode u_seg7_decode (
    .bcd_i (digit_sel),
    .seg_o (seg_raw)
  );

`ifdef ALU_DISP_LZ_BLANK_EN
  assign seg_o = ((dig_q == DIG_TENS) && (tens_q == 4'd0)) ? SEG_BLANK : seg_raw;
`else
  assign seg_o = seg_raw;
`endif

  assign ready_o   = (state_q == IDLE);
  assign leds_o    = leds_q;
  assign dig_sel_o = dig_q;

endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] result_i;
  logic       valid_i;
  logic       ready_o;
  logic [5:0] leds_o;
  logic [6:0] seg_o;
  logic [1:0] dig_sel_o;

  int checks = 0;
  int errors = 0;

`ifdef ALU_DISP_LZ_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'b0000000;
`else
  localparam logic [6:0] TENS_ZERO = 7'b0111111;
`endif

  always #5 clk = ~clk;

  alu_result_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .result_i  (result_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .leds_o    (leds_o),
    .seg_o     (seg_o),
    .dig_sel_o (dig_sel_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_dig(input logic [1:0] want);
    for (int i = 0; i < 20 && dig_sel_o !== want; i++) tick();
    check("dig_wait", {6'd0, dig_sel_o}, {6'd0, want});
  endtask

  task automatic accept(input logic [5:0] val);
    result_i = val;
    valid_i  = 1'b1;
    tick();
    valid_i  = 1'b0;
  endtask

  initial begin
    logic [1:0] dig_exp [9];
    dig_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    rst = 1'b1; valid_i = 1'b0; result_i = '0;
    tick(); tick();
    // Reset state
    check("rst_ready", {7'd0, ready_o}, 8'd1);
    check("rst_leds", {2'd0, leds_o}, 8'd0);
    check("rst_dig", {6'd0, dig_sel_o}, 8'b01);
    check("rst_seg", {1'b0, seg_o}, 8'b0111111);
    rst = 1'b0;

    // Refresh sequence with REFRESH_DIV=4
    for (int i = 0; i < 9; i++) begin
      if (i != 0) tick();
      check("refresh_seq", {6'd0, dig_sel_o}, {6'd0, dig_exp[i]});
    end

    // 63 -> 6/3, latency 8 edges
    accept(6'd63);
    check("busy_after_accept", {7'd0, ready_o}, 8'd0);
    for (int i = 0; i < 6; i++) tick();
    check("busy_edge7", {7'd0, ready_o}, 8'd0);
    check("leds_hold_edge7", {2'd0, leds_o}, 8'd0);
    tick();
    check("ready_edge8", {7'd0, ready_o}, 8'd1);
    check("leds_63", {2'd0, leds_o}, 8'd63);
    wait_dig(2'b01);
    check("seg_63_units", {1'b0, seg_o}, 8'b1001111);
    wait_dig(2'b10);
    check("seg_63_tens", {1'b0, seg_o}, 8'b1111101);

    // 42 accepted, 17 offered while busy is dropped
    accept(6'd42);
    tick();
    result_i = 6'd17; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("busy_drop", {7'd0, ready_o}, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    check("leds_42", {2'd0, leds_o}, 8'd42);
    tick();
    check("no_requeue", {7'd0, ready_o}, 8'd1);
    wait_dig(2'b01);
    check("seg_42_units", {1'b0, seg_o}, 8'b1011011);
    wait_dig(2'b10);
    check("seg_42_tens", {1'b0, seg_o}, 8'b1100110);

    // valid held high: second accept on edge 9
    result_i = 6'd5; valid_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("leds_5", {2'd0, leds_o}, 8'd5);
    check("ready_held", {7'd0, ready_o}, 8'd1);
    result_i = 6'd12;
    tick();
    valid_i = 1'b0;
    check("accept_edge9", {7'd0, ready_o}, 8'd0);
    for (int i = 0; i < 7; i++) tick();
    check("leds_12", {2'd0, leds_o}, 8'd12);

    // Reset mid-conversion
    accept(6'd55);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", {7'd0, ready_o}, 8'd1);
    check("midrst_leds", {2'd0, leds_o}, 8'd0);
    check("midrst_dig", {6'd0, dig_sel_o}, 8'b01);
    check("midrst_seg", {1'b0, seg_o}, 8'b0111111);
    accept(6'd9);
    for (int i = 0; i < 7; i++) tick();
    check("leds_9", {2'd0, leds_o}, 8'd9);
    wait_dig(2'b01);
    check("seg_9_units", {1'b0, seg_o}, 8'b1101111);
    wait_dig(2'b10);
    check("seg_9_tens", {1'b0, seg_o}, {1'b0, TENS_ZERO});

    // 7: leading-zero behaviour
    accept(6'd7);
    for (int i = 0; i < 7; i++) tick();
    check("leds_7", {2'd0, leds_o}, 8'd7);
    wait_dig(2'b01);
    check("seg_7_units", {1'b0, seg_o}, 8'b0000111);
    wait_dig(2'b10);
    check("seg_7_tens", {1'b0, seg_o}, {1'b0, TENS_ZERO});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
